btb_nway: RTL



---
 rtl/btb_pkg.sv | 22 ++
 rtl/btb_lru_ages.sv | 51 +++++
 rtl/btb_nway_chk.sv | 14 +
 rtl/btb_nway.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_ALLOC        = 2'd2;
    localparam logic [CTR_W-1:0] CTR_MAX          = 2'd3;
    localparam logic [CTR_W-1:0] CTR_TAKEN_THRESH = 2'd2;

    typedef enum logic [0:0] {
        BTB_IDLE  = 1'b0,
        BTB_FLUSH = 1'b1
    } btb_state_e;

    function automatic logic [CTR_W-1:0] ctr_sat_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + 2'd1;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_sat_dec(input logic [CTR_W-1:0] c);
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_lru_ages.sv
// Per-set true-LRU age logic: victim selection and age update on a touch.
module btb_lru_ages #(
    parameter int NUM_WAYS = 2,
    parameter int AGE_W    = 1
) (
    input  logic [NUM_WAYS-1:0][AGE_W-1:0] i_ages,
    input  logic [NUM_WAYS-1:0]            i_valid,
    input  logic                           i_touch_en,
    input  logic [AGE_W-1:0]               i_touch_way,
    output logic [NUM_WAYS-1:0][AGE_W-1:0] o_ages_next,
    output logic [AGE_W-1:0]               o_victim
);

    logic [AGE_W-1:0] w_inv_way;
    logic [AGE_W-1:0] w_old_way;
    logic [AGE_W-1:0] w_old_age;
    logic [AGE_W-1:0] w_ref_age;

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        w_inv_way = {AGE_W{1'b0}};
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            w_inv_way = i_valid[w] ? w_inv_way : AGE_W'(w);
        end
        w_old_way = {AGE_W{1'b0}};
        w_old_age = i_ages[0];
        for (int w = 1; w < NUM_WAYS; w++) begin
            w_old_way = (i_ages[w] > w_old_age) ? AGE_W'(w) : w_old_way;
            w_old_age = (i_ages[w] > w_old_age) ? i_ages[w] : w_old_age;
        end
        o_victim = (&i_valid) ? w_old_way : w_inv_way;
    end

    // Touch: a way being filled counts as the oldest, so every younger way ages past it.
    always_comb begin
        o_ages_next = i_ages;
        w_ref_age   = i_valid[i_touch_way] ? i_ages[i_touch_way] : AGE_W'(NUM_WAYS - 1);
        for (int v = 0; v < NUM_WAYS; v++) begin
            if (!i_touch_en) begin
                o_ages_next[v] = i_ages[v];
            end else if (AGE_W'(v) == i_touch_way) begin
                o_ages_next[v] = {AGE_W{1'b0}};
            end else if (i_ages[v] < w_ref_age) begin
                o_ages_next[v] = i_ages[v] + AGE_W'(1);
            end else begin
                o_ages_next[v] = i_ages[v];
            end
        end
    end

endmodule

// File: rtl/btb_nway_chk.sv
// Structural invariants of the BTB: a tag never matches two valid ways of one set.
module btb_nway_chk #(
    parameter int NUM_WAYS = 2
) (
    input logic                clk,
    input logic                rst,
    input logic [NUM_WAYS-1:0] i_lk_match,
    input logic [NUM_WAYS-1:0] i_upd_match
);

    a_lk_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(i_lk_match));
    a_upd_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(i_upd_match));

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer with 2-bit direction counters,
// per-set true-LRU replacement and a one-set-per-cycle flush sweep.
module btb_nway
    import btb_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic [PC_W-1:0] lookup_target,
    output logic            lookup_taken,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            flush_req,
    output logic            flush_busy
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = PC_W - 2 - IDX_W;
    localparam int AGE_W = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0]            r_valid  [NUM_SETS];
    logic [TAG_W-1:0]               r_tag    [NUM_SETS][NUM_WAYS];
    logic [PC_W-1:0]                r_target [NUM_SETS][NUM_WAYS];
    logic [CTR_W-1:0]               r_ctr    [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0][AGE_W-1:0] r_ages   [NUM_SETS];
    btb_state_e                     r_state;
    logic [IDX_W-1:0]               r_flush_idx;

    logic [IDX_W-1:0]               w_lk_idx;
    logic [TAG_W-1:0]               w_lk_tag;
    logic [NUM_WAYS-1:0]            w_lk_match;
    logic [AGE_W-1:0]               w_lk_way;
    logic                           w_lk_hit;
    logic [IDX_W-1:0]               w_upd_idx;
    logic [TAG_W-1:0]               w_upd_tag;
    logic [NUM_WAYS-1:0]            w_upd_match;
    logic [AGE_W-1:0]               w_upd_way;
    logic                           w_upd_hit;
    logic                           w_upd_fire;
    logic                           w_touch_en;
    logic [AGE_W-1:0]               w_touch_way;
    logic [AGE_W-1:0]               w_victim;
    logic [NUM_WAYS-1:0][AGE_W-1:0] w_ages_next;
    logic                           w_unused_lsbs;

    assign w_lk_idx      = lookup_pc[IDX_W+1:2];
    assign w_lk_tag      = lookup_pc[PC_W-1:IDX_W+2];
    assign w_upd_idx     = upd_pc[IDX_W+1:2];
    assign w_upd_tag     = upd_pc[PC_W-1:IDX_W+2];
    assign w_unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign upd_ready   = (r_state == BTB_IDLE);
    assign flush_busy  = (r_state == BTB_FLUSH);
    assign w_upd_fire  = upd_valid && upd_ready;
    assign w_touch_en  = w_upd_fire && (w_upd_hit || upd_taken);
    assign w_touch_way = w_upd_hit ? w_upd_way : w_victim;

    // Tag compare on the fetch-indexed set; matches are one-hot so OR-encoding is exact.
    always_comb begin
        w_lk_match = {NUM_WAYS{1'b0}};
        w_lk_way   = {AGE_W{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_lk_match[w] = r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag);
            w_lk_way      = w_lk_way | (w_lk_match[w] ? AGE_W'(w) : {AGE_W{1'b0}});
        end
        w_lk_hit = |w_lk_match;
    end

    // Tag compare on the update-indexed set.
    always_comb begin
        w_upd_match = {NUM_WAYS{1'b0}};
        w_upd_way   = {AGE_W{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_upd_match[w] = r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag);
            w_upd_way      = w_upd_way | (w_upd_match[w] ? AGE_W'(w) : {AGE_W{1'b0}});
        end
        w_upd_hit = |w_upd_match;
    end

    // Lookup outputs read pre-write state and are suppressed while sweeping.
    always_comb begin
        if (r_state == BTB_FLUSH) begin
            lookup_hit    = 1'b0;
            lookup_target = {PC_W{1'b0}};
            lookup_taken  = 1'b0;
        end else begin
            lookup_hit    = w_lk_hit;
            lookup_target = w_lk_hit ? r_target[w_lk_idx][w_lk_way] : {PC_W{1'b0}};
            lookup_taken  = w_lk_hit && (r_ctr[w_lk_idx][w_lk_way] >= CTR_TAKEN_THRESH);
        end
    end

    btb_lru_ages #(
        .NUM_WAYS (NUM_WAYS),
        .AGE_W    (AGE_W)
    ) u_lru (
        .i_ages      (r_ages[w_upd_idx]),
        .i_valid     (r_valid[w_upd_idx]),
        .i_touch_en  (w_touch_en),
        .i_touch_way (w_touch_way),
        .o_ages_next (w_ages_next),
        .o_victim    (w_victim)
    );

    btb_nway_chk #(
        .NUM_WAYS (NUM_WAYS)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_lk_match  (w_lk_match),
        .i_upd_match (w_upd_match)
    );

    // Storage update plus IDLE/FLUSH sequencing; an update accepted in IDLE lands before a sweep starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BTB_IDLE;
            r_flush_idx <= {IDX_W{1'b0}};
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= {NUM_WAYS{1'b0}};
                r_ages[s]  <= {(NUM_WAYS*AGE_W){1'b0}};
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_tag[s][w]    <= {TAG_W{1'b0}};
                    r_target[s][w] <= {PC_W{1'b0}};
                    r_ctr[s][w]    <= 2'd0;
                end
            end
        end else begin
            if (w_upd_fire && w_upd_hit) begin
                r_ctr[w_upd_idx][w_upd_way] <= upd_taken ? ctr_sat_inc(r_ctr[w_upd_idx][w_upd_way])
                                                         : ctr_sat_dec(r_ctr[w_upd_idx][w_upd_way]);
                if (upd_taken) begin
                    r_target[w_upd_idx][w_upd_way] <= upd_target;
                end
                r_ages[w_upd_idx] <= w_ages_next;
            end else if (w_upd_fire && upd_taken) begin
                r_valid[w_upd_idx][w_victim]  <= 1'b1;
                r_tag[w_upd_idx][w_victim]    <= w_upd_tag;
                r_target[w_upd_idx][w_victim] <= upd_target;
                r_ctr[w_upd_idx][w_victim]    <= CTR_ALLOC;
                r_ages[w_upd_idx]             <= w_ages_next;
            end
            case (r_state)
                BTB_IDLE: begin
                    if (flush_req) begin
                        r_state     <= BTB_FLUSH;
                        r_flush_idx <= {IDX_W{1'b0}};
                    end
                end
                BTB_FLUSH: begin
                    r_valid[r_flush_idx] <= {NUM_WAYS{1'b0}};
                    r_ages[r_flush_idx]  <= {(NUM_WAYS*AGE_W){1'b0}};
                    r_flush_idx          <= r_flush_idx + IDX_W'(1);
                    if (r_flush_idx == IDX_W'(NUM_SETS - 1)) begin
                        r_state <= BTB_IDLE;
                    end
                end
                default: begin
                    r_state <= BTB_IDLE;
                end
            endcase
        end
    end

endmodule
